spike_generator_array: RTL
==========================

# spike_generator_array

Parametrised bank of periodic spike generators that emits tag/count words toward the BD encoder path. Each generator holds a programmable period, phase countdown, tag and spike count; it fires once every `period` FPGA time units. Generator state is stored internally and swept by a single FSM once per time unit. Stalled output sweeps are tolerated: the block queues missed time units instead of dropping them. This generalises the earlier fixed-count generator by adding per-generator spike counts, a pending-unit queue and an overflow flag.

## Interface
- `Ngens`, 8: generator index width; `2**Ngens` generators.
- `Nperiod`, 16: period/ticks width.
- `Ntag`, 11: tag width.
- `Nct`, 9: spike-count width.
- `Npend`, 4: pending time-unit counter width.

- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `time_unit` in 1: one-cycle pulse per FPGA time unit.
- `gens_used` in Ngens: highest generator index swept.
- `gens_en` in 2**Ngens: per-generator enable.
- `prog_gen_idx` in Ngens: generator index to program.
- `prog_period` in Nperiod: period to program.
- `prog_ticks` in Nperiod: initial countdown to program.
- `prog_tag` in Ntag: tag to program.
- `prog_ct` in Nct: spike count to program.
- `prog_v` in 1: programming word valid.
- `prog_a` out 1: programming word accepted.
- `out_tag` out Ntag: emitted tag.
- `out_ct` out Nct: emitted spike count.
- `out_v` out 1: output valid.
- `out_a` in 1: output accepted.
- `busy` out 1: a sweep is in progress or time units are pending.
- `pend_overflow` out 1: sticky flag; a time unit was lost.

## Operation
- **Handshakes.** Both channels are synchronous valid/ack. A word transfers on a rising edge where `v && a`.
- **Generator state.** Each generator holds `period`, `ticks`, `tag` and `ct`. All fields reset to 0. A generator with `period == 0` never fires.
- **Programming.**
  - `prog_a = 1` only in IDLE with `pend == 0`.
  - A transfer overwrites all four fields of `prog_gen_idx` on that edge.
- **Pending counter `pend`** (`Npend` bits):
  - Increments on each `time_unit` pulse.
  - Decrements when a sweep starts.
  - Increment and decrement on the same edge leave it unchanged.
  - At all-ones, a further `time_unit` is dropped and sets `pend_overflow`. The flag clears only on reset.
- **FSM states:**
  - IDLE: if `pend > 0`, set `idx = 0`, decrement `pend`, go to SCAN.
  - SCAN, evaluating generator `idx`:
    - Skip if `!gens_en[idx]` or `period == 0`: state unchanged.
    - Else if `ticks == 0`: latch `tag`/`ct` into the output registers, set `ticks ← period − 1`, go to EMIT.
    - Else: `ticks ← ticks − 1`.
    - For a non-firing generator, advance: if `idx == gens_used`, go to IDLE, else `idx + 1` and stay in SCAN.
  - EMIT: `out_v = 1` with stable data until `out_a`. On transfer, advance exactly as in SCAN.
- **Arithmetic.** `ticks` arithmetic is unsigned with no wrap; `period − 1` applies only when `period ≥ 1`. `gens_used` and `gens_en` are sampled live each SCAN cycle.
- **Reset mid-operation.** Asserting `reset_n` low clears all state at once: FSM to IDLE, `out_v = 0`, `pend = 0`, `pend_overflow = 0`, all generators zeroed.

## Timing
- Reset values: `prog_a = 0` while in reset, then 1 from the first edge after release. `out_v = 0`, `out_tag = 0`, `out_ct = 0`, `busy = 0`, `pend_overflow = 0`.
- `busy = (state != IDLE) || (pend != 0)`, registered-state based.
- **`time_unit` at edge N:**
  - `pend = 1` after N.
  - IDLE→SCAN at edge N+1, evaluating `idx = 0` in cycle N+1.
- **Per-generator cost:** one cycle if not firing. A firing generator costs one SCAN cycle plus EMIT cycles until the transfer. `out_v` rises the cycle after its SCAN cycle.
- **Sweep length:** with no stall, `gens_used + 1` SCAN cycles plus one EMIT cycle per firing.
- **Back-to-back sweeps:** the edge leaving the last generator goes to IDLE. If `pend > 0`, the next sweep starts one cycle later.
- **Simultaneous events:**
  - `time_unit` together with a programming transfer: both occur. The sweep uses the new values.
  - `time_unit` during a sweep: only increments `pend`.

## Test plan
- **Single generator fires every third unit.** Program gen 0 with period=3, ticks=0, tag=0x155, ct=2; `gens_used=0`, `gens_en[0]=1`, `out_a=1`; pulse `time_unit` 7 times, spaced 10 cycles. Required: outputs (0x155, 2) on units 1, 4 and 7 only. `out_v` rises 2 cycles after the pulse edge.
- **Disable/skip.** Program gens 0–3 with period=1 and tags 10–13; `gens_en=4'b1010`, `gens_used=3`. Required: per unit, exactly tags 11 then 13, in that order. Gen 3 fires, but gen 5 (beyond `gens_used`) never does.
- **Output stall and pending queue.** Same setup as the first test but period=1. Hold `out_a=0` for 50 cycles while pulsing `time_unit` 3 times. Required: `pend` reaches 2 (the first pulse started the sweep). After release, 3 outputs arrive back-to-back with one IDLE cycle between sweeps. `busy` falls after the last transfer.
- **Overflow.** With `Npend=4` and `out_a=0`, pulse `time_unit` 17 times. Required: the first pulse starts a sweep and the next 15 fill `pend` to 15. The 17th pulse sets `pend_overflow=1`, which stays set after the drain.
- **Programming lockout.** Assert `prog_v` while `busy`. Required: `prog_a=0` until `busy=0`, then the word is accepted within 1 cycle. Also, `time_unit` on the same edge as an accepted program: the next sweep uses the newly programmed values.
- **Reset mid-EMIT.** Pull `reset_n` low while `out_v=1`. Required: `out_v=0` immediately and `pend=0`. After release, gen 0 does not fire (period=0).

Source files
------------

// File: rtl/spike_generator_array_if.sv
// Programming and output channels of the spike generator bank.
// Both channels are valid/ack; a word moves on a clock edge where v && a.
interface spike_generator_array_if #(
    parameter int Ngens   = 8,
    parameter int Nperiod = 16,
    parameter int Ntag    = 11,
    parameter int Nct     = 9
);
    logic [Ngens-1:0]   prog_gen_idx;
    logic [Nperiod-1:0] prog_period;
    logic [Nperiod-1:0] prog_ticks;
    logic [Ntag-1:0]    prog_tag;
    logic [Nct-1:0]     prog_ct;
    logic               prog_v;
    logic               prog_a;
    logic [Ntag-1:0]    out_tag;
    logic [Nct-1:0]     out_ct;
    logic               out_v;
    logic               out_a;

    modport master (
        output prog_gen_idx, prog_period, prog_ticks, prog_tag, prog_ct,
        output prog_v, out_a,
        input  prog_a, out_tag, out_ct, out_v
    );

    modport slave (
        input  prog_gen_idx, prog_period, prog_ticks, prog_tag, prog_ct,
        input  prog_v, out_a,
        output prog_a, out_tag, out_ct, out_v
    );
endinterface

// File: rtl/spike_generator_array.sv
// Bank of periodic spike generators swept once per time unit by one FSM.
// Missed time units are queued in a pending counter rather than dropped.
module spike_generator_array #(
    parameter int Ngens   = 8,
    parameter int Nperiod = 16,
    parameter int Ntag    = 11,
    parameter int Nct     = 9,
    parameter int Npend   = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                time_unit,
    input  logic [Ngens-1:0]    gens_used,
    input  logic [2**Ngens-1:0] gens_en,
    spike_generator_array_if.slave bus,
    output logic                busy,
    output logic                pend_overflow
);
    localparam int NG = 2**Ngens;

    typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_e;

    state_e             state_q, state_d;
    logic [Ngens-1:0]   idx_q, idx_d;
    logic [Npend-1:0]   pend_q, pend_d;
    logic               ovf_q, ovf_d;
    logic               prog_a_q;
    logic               out_v_q, out_v_d;
    logic [Ntag-1:0]    out_tag_q, out_tag_d;
    logic [Nct-1:0]     out_ct_q, out_ct_d;

    logic [Nperiod-1:0] period_q [NG];
    logic [Nperiod-1:0] ticks_q  [NG];
    logic [Ntag-1:0]    tag_q    [NG];
    logic [Nct-1:0]     ct_q     [NG];

    logic               prog_xfer, start, skip, fire, last;
    logic               tick_we;
    logic [Nperiod-1:0] tick_wd;

    always_comb begin
        prog_xfer = bus.prog_v && prog_a_q;
        start     = (state_q == IDLE) && (pend_q != '0);
        skip      = !gens_en[idx_q] || (period_q[idx_q] == '0);
        fire      = !skip && (ticks_q[idx_q] == '0);
        last      = (idx_q == gens_used);

        state_d   = state_q;
        idx_d     = idx_q;
        pend_d    = pend_q;
        ovf_d     = ovf_q;
        out_v_d   = out_v_q;
        out_tag_d = out_tag_q;
        out_ct_d  = out_ct_q;
        tick_we   = 1'b0;
        tick_wd   = ticks_q[idx_q] - 1'b1;

        // A pulse arriving at all-ones with no sweep starting is lost.
        if (time_unit && !start) begin
            if (&pend_q) ovf_d  = 1'b1;
            else         pend_d = pend_q + 1'b1;
        end else if (!time_unit && start) begin
            pend_d = pend_q - 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (fire) begin
                    out_tag_d = tag_q[idx_q];
                    out_ct_d  = ct_q[idx_q];
                    out_v_d   = 1'b1;
                    tick_we   = 1'b1;
                    tick_wd   = period_q[idx_q] - 1'b1;
                    state_d   = EMIT;
                end else begin
                    tick_we = !skip;
                    if (last) state_d = IDLE;
                    else      idx_d   = idx_q + 1'b1;
                end
            end
            EMIT: begin
                if (bus.out_a) begin
                    out_v_d = 1'b0;
                    if (last) state_d = IDLE;
                    else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = SCAN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pend_q    <= '0;
            ovf_q     <= 1'b0;
            prog_a_q  <= 1'b0;
            out_v_q   <= 1'b0;
            out_tag_q <= '0;
            out_ct_q  <= '0;
            for (int i = 0; i < NG; i++) begin
                period_q[i] <= '0;
                ticks_q[i]  <= '0;
                tag_q[i]    <= '0;
                ct_q[i]     <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
            prog_a_q  <= (state_d == IDLE) && (pend_d == '0);
            out_v_q   <= out_v_d;
            out_tag_q <= out_tag_d;
            out_ct_q  <= out_ct_d;
            if (tick_we) ticks_q[idx_q] <= tick_wd;
            // Programming is only accepted in IDLE, so it never meets a tick write.
            if (prog_xfer) begin
                period_q[bus.prog_gen_idx] <= bus.prog_period;
                ticks_q[bus.prog_gen_idx]  <= bus.prog_ticks;
                tag_q[bus.prog_gen_idx]    <= bus.prog_tag;
                ct_q[bus.prog_gen_idx]     <= bus.prog_ct;
            end
        end
    end

    assign bus.prog_a    = prog_a_q;
    assign bus.out_v     = out_v_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.out_ct    = out_ct_q;
    assign busy          = (state_q != IDLE) || (pend_q != '0);
    assign pend_overflow = ovf_q;
endmodule
